// File: rtl/ctrl_unit_irq.sv
// One-hot instruction sequencer with a prioritised, maskable interrupt
// controller, push-PC sequence and memory-wait timeout.
module ctrl_unit_irq #(
    parameter int NUM_IRQ     = 4,
    parameter int IRQ_ID_W    = 2,
    parameter int IRQ_WAIT    = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                I_clk,
    input  logic                I_reset_n,
    input  logic                I_needs_mem,
    input  logic                I_mem_write,
    input  logic                I_mem_ready,
    input  logic                I_data_ready,
    input  logic                I_irq_enabled,
    input  logic [NUM_IRQ-1:0]  I_irq_req,
    input  logic [NUM_IRQ-1:0]  I_irq_mask,
    output logic [8:0]          O_state,
    output logic                O_execute,
    output logic                O_irq_ack,
    output logic [IRQ_ID_W-1:0] O_irq_id,
    output logic                O_push_pc,
    output logic                O_bus_error
);

    localparam int S_FETCH = 0;
    localparam int S_DEC   = 1;
    localparam int S_RR    = 2;
    localparam int S_EX    = 3;
    localparam int S_MEM   = 4;
    localparam int S_WB    = 5;
    localparam int S_IRQ   = 6;
    localparam int S_SAVE  = 7;
    localparam int S_ISR   = 8;

    localparam logic [8:0] ST_FETCH = 9'b000000001;
    localparam logic [8:0] ST_DEC   = 9'b000000010;
    localparam logic [8:0] ST_RR    = 9'b000000100;
    localparam logic [8:0] ST_EX    = 9'b000001000;
    localparam logic [8:0] ST_MEM   = 9'b000010000;
    localparam logic [8:0] ST_WB    = 9'b000100000;
    localparam logic [8:0] ST_IRQ   = 9'b001000000;
    localparam logic [8:0] ST_SAVE  = 9'b010000000;
    localparam logic [8:0] ST_ISR   = 9'b100000000;

    localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int WT_W = (IRQ_WAIT < 2) ? 1 : $clog2(IRQ_WAIT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TIMEOUT);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(IRQ_WAIT - 1);

    logic [8:0]          state;
    logic [8:0]          nxt;
    logic                mem_wait;
    logic                saving;
    logic                nm_q;
    logic                mw_q;
    logic [TO_W-1:0]     to_cnt;
    logic [WT_W-1:0]     wt_cnt;
    logic [NUM_IRQ-1:0]  pending;
    logic [IRQ_ID_W-1:0] win_id;
    logic                irq_hit;
    logic                in_mem;
    logic                issue;
    logic                done;
    logic                tout;

    assign pending = I_irq_req & ~I_irq_mask;
    assign irq_hit = I_irq_enabled & (|pending);
    assign in_mem  = state[S_FETCH] | state[S_MEM];
    assign issue   = in_mem & ~mem_wait & I_mem_ready;
    // Fetches are reads; MEM completes on mem_ready only for writes.
    assign done    = in_mem & mem_wait &
                     ((state[S_MEM] & mw_q) ? I_mem_ready : I_data_ready);
    assign tout    = (MEM_TIMEOUT != 0) & in_mem & ~done & (to_cnt == TO_MAX);
    assign O_state = state;

    // Lowest-index pending line wins: scan downward so it is written last.
    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) win_id = IRQ_ID_W'(i);
        end
    end

    // State register.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) state <= ST_FETCH;
        else            state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = ST_FETCH;
        unique case (1'b1)
            state[S_FETCH]: nxt = done ? ST_DEC : (tout ? ST_WB : ST_FETCH);
            state[S_DEC]:   nxt = ST_RR;
            state[S_RR]:    nxt = ST_EX;
            state[S_EX]:    nxt = nm_q ? ST_MEM : ST_WB;
            state[S_MEM]:   nxt = (done | tout) ? ST_WB : ST_MEM;
            state[S_WB]:    nxt = saving ? ST_ISR : (irq_hit ? ST_IRQ : ST_FETCH);
            state[S_IRQ]:   nxt = (wt_cnt == WT_LAST) ? ST_SAVE : ST_IRQ;
            state[S_SAVE]:  nxt = ST_MEM;
            state[S_ISR]:   nxt = ST_FETCH;
            default:        nxt = ST_FETCH;
        endcase
    end

    // Strobe outputs; the issue strobe is held off while reset is asserted.
    always_comb begin
        O_execute   = issue & ~tout & I_reset_n;
        O_irq_ack   = state[S_WB] & ~saving & irq_hit;
        O_bus_error = tout;
    end

    // Handshake, timers, latched decode bits and interrupt bookkeeping.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            mem_wait  <= 1'b0;
            saving    <= 1'b0;
            nm_q      <= 1'b0;
            mw_q      <= 1'b0;
            to_cnt    <= '0;
            wt_cnt    <= '0;
            O_irq_id  <= '0;
            O_push_pc <= 1'b0;
        end else begin
            if (done | tout) mem_wait <= 1'b0;
            else if (issue)  mem_wait <= 1'b1;
            to_cnt <= (in_mem && nxt == state) ? to_cnt + 1'b1 : '0;
            wt_cnt <= (state[S_IRQ] && nxt == state) ? wt_cnt + 1'b1 : '0;
            if (state[S_DEC]) begin
                nm_q <= I_needs_mem;
                mw_q <= I_mem_write;
            end
            if (state[S_SAVE]) begin
                nm_q      <= 1'b1;
                mw_q      <= 1'b1;
                saving    <= 1'b1;
                O_push_pc <= 1'b1;
            end
            if (state[S_WB] && saving) begin
                saving    <= 1'b0;
                O_push_pc <= 1'b0;
            end
            if (O_irq_ack) O_irq_id <= win_id;
        end
    end

endmodule

// File: tb/tb_ctrl_unit_irq.sv
// Randomized transaction-level bench for ctrl_unit_irq.
// Expected traces are built per instruction from phase lengths.
module tb_ctrl_unit_irq;

    localparam int TOUT = 15;
    localparam int IWAIT = 2;

    localparam logic [8:0] ST_FETCH = 9'd1;
    localparam logic [8:0] ST_DEC   = 9'd2;
    localparam logic [8:0] ST_RR    = 9'd4;
    localparam logic [8:0] ST_EX    = 9'd8;
    localparam logic [8:0] ST_MEM   = 9'd16;
    localparam logic [8:0] ST_WB    = 9'd32;
    localparam logic [8:0] ST_IRQ   = 9'd64;
    localparam logic [8:0] ST_SAVE  = 9'd128;
    localparam logic [8:0] ST_ISR   = 9'd256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       needs_mem, mem_write, mem_ready, data_ready;
    logic       irq_en;
    logic [3:0] irq_req, irq_mask;
    logic [8:0] o_state;
    logic       o_exec, o_ack, o_push, o_berr;
    logic [1:0] o_id;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_id = 2'd0;
    bit exp_push = 1'b0;

    ctrl_unit_irq #(
        .NUM_IRQ(4), .IRQ_ID_W(2), .IRQ_WAIT(IWAIT), .MEM_TIMEOUT(TOUT)
    ) dut (
        .I_clk(clk),
        .I_reset_n(rst_n),
        .I_needs_mem(needs_mem),
        .I_mem_write(mem_write),
        .I_mem_ready(mem_ready),
        .I_data_ready(data_ready),
        .I_irq_enabled(irq_en),
        .I_irq_req(irq_req),
        .I_irq_mask(irq_mask),
        .O_state(o_state),
        .O_execute(o_exec),
        .O_irq_ack(o_ack),
        .O_irq_id(o_id),
        .O_push_pc(o_push),
        .O_bus_error(o_berr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic noise();
        needs_mem  = 1'($urandom);
        mem_write  = 1'($urandom);
        mem_ready  = 1'($urandom);
        data_ready = 1'($urandom);
        irq_en     = 1'($urandom);
        irq_req    = 4'($urandom);
        irq_mask   = 4'($urandom);
    endtask

    // Check one cycle at the falling edge, then move to just after the next rise.
    task automatic step(input logic [8:0] st, input bit ex, input bit ack,
                        input bit be);
        @(negedge clk);
        chk("state", 32'(o_state), 32'(st));
        chk("execute", 32'(o_exec), 32'(ex));
        chk("irq_ack", 32'(o_ack), 32'(ack));
        chk("bus_error", 32'(o_berr), 32'(be));
        chk("push_pc", 32'(o_push), 32'(exp_push));
        chk("irq_id", 32'(o_id), 32'(exp_id));
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 40;
        if (r == 1) return 15;
        return int'($urandom_range(1, 5));
    endfunction

    // Memory phase: issue after d idle cycles, completion lat cycles later.
    task automatic mem_phase(input logic [8:0] st, input bit wr, input int d,
                             input int lat, output bit to);
        int c;
        bit be;
        c = d + lat;
        to = 1'b0;
        for (int k = 0; k <= TOUT; k++) begin
            noise();
            if (k < d) mem_ready = 1'b0;
            else if (k == d) mem_ready = 1'b1;
            else if (wr) mem_ready = (k == c);
            if (!wr && k > d) data_ready = (k == c);
            be = (k == TOUT) && (k != c);
            step(st, (k == d), 1'b0, be);
            if (k == c) break;
            if (be) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic wb_phase(input bit en, input logic [3:0] req,
                            input logic [3:0] mask);
        logic [3:0] pend;
        int win;
        bit hit, t;
        pend = req & ~mask;
        win = -1;
        for (int i = 0; i < 4; i++) if (pend[i] && win < 0) win = i;
        hit = en && (win >= 0);
        noise();
        irq_en = en;
        irq_req = req;
        irq_mask = mask;
        step(ST_WB, 1'b0, hit, 1'b0);
        if (!hit) return;
        exp_id = 2'(win);
        for (int w = 0; w < IWAIT; w++) begin
            noise();
            step(ST_IRQ, 1'b0, 1'b0, 1'b0);
        end
        noise();
        step(ST_SAVE, 1'b0, 1'b0, 1'b0);
        exp_push = 1'b1;
        mem_phase(ST_MEM, 1'b1, int'($urandom_range(0, 2)), pick_lat(), t);
        noise();
        irq_en = 1'b1;
        irq_req = 4'hf;
        irq_mask = 4'h0;
        step(ST_WB, 1'b0, 1'b0, 1'b0);
        exp_push = 1'b0;
        noise();
        step(ST_ISR, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input bit nm, input bit wr, input int fd,
                             input int fl, input int md, input int ml,
                             input bit en, input logic [3:0] req,
                             input logic [3:0] mask);
        bit t;
        mem_phase(ST_FETCH, 1'b0, fd, fl, t);
        if (!t) begin
            noise();
            needs_mem = nm;
            mem_write = wr;
            step(ST_DEC, 1'b0, 1'b0, 1'b0);
            noise();
            step(ST_RR, 1'b0, 1'b0, 1'b0);
            noise();
            step(ST_EX, 1'b0, 1'b0, 1'b0);
            if (nm) mem_phase(ST_MEM, wr, md, ml, t);
        end
        wb_phase(en, req, mask);
    endtask

    initial begin
        rst_n = 1'b0;
        noise();
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 32'(o_state), 32'(ST_FETCH));
            chk("rst_exec", 32'(o_exec), 32'd0);
            chk("rst_ack", 32'(o_ack), 32'd0);
            chk("rst_berr", 32'(o_berr), 32'd0);
            chk("rst_push", 32'(o_push), 32'd0);
            chk("rst_id", 32'(o_id), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(0, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0);
        run_instr(1, 0, 0, 1, 0, 3, 0, 4'h0, 4'h0);
        run_instr(1, 1, 1, 2, 0, 1, 0, 4'h0, 4'h0);
        run_instr(0, 0, 0, 1, 0, 1, 1, 4'b1010, 4'b0010);
        run_instr(0, 0, 2, 1, 0, 1, 0, 4'hf, 4'h0);
        run_instr(0, 0, 0, 2, 0, 1, 1, 4'h5, 4'h5);
        run_instr(0, 0, 0, 100, 0, 1, 0, 4'h0, 4'h0);
        run_instr(0, 0, 0, 15, 0, 1, 0, 4'h0, 4'h0);
        run_instr(1, 0, 0, 1, 2, 40, 0, 4'h0, 4'h0);
        run_instr(1, 1, 0, 1, 0, 15, 1, 4'b1100, 4'b0000);

        begin
            bit t;
            noise();
            mem_phase(ST_FETCH, 1'b0, 0, 1, t);
            noise();
            needs_mem = 1'b1;
            mem_write = 1'b0;
            step(ST_DEC, 1'b0, 1'b0, 1'b0);
            noise();
            step(ST_RR, 1'b0, 1'b0, 1'b0);
            noise();
            step(ST_EX, 1'b0, 1'b0, 1'b0);
            noise();
            mem_ready = 1'b1;
            data_ready = 1'b0;
            step(ST_MEM, 1'b1, 1'b0, 1'b0);
            mem_ready = 1'b0;
            data_ready = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_state", 32'(o_state), 32'(ST_FETCH));
            chk("mid_rst_exec", 32'(o_exec), 32'd0);
            chk("mid_rst_ack", 32'(o_ack), 32'd0);
            chk("mid_rst_berr", 32'(o_berr), 32'd0);
            chk("mid_rst_push", 32'(o_push), 32'd0);
            chk("mid_rst_id", 32'(o_id), 32'd0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            exp_id = 2'd0;
            exp_push = 1'b0;
            run_instr(0, 0, 0, 1, 0, 1, 0, 4'h0, 4'h0);
        end

        for (int n = 0; n < 200; n++) begin
            run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                      pick_lat(), int'($urandom_range(0, 3)), pick_lat(),
                      1'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_irq.md
Name: ctrl_unit_irq

Overview:
- Parametrised successor to the CPU's one-hot control sequencer.
- Runs fetch/decode/regread/execute/mem/writeback for each instruction.
- Adds a prioritised, maskable multi-channel interrupt controller with an ID output, a push-PC sequence issued through the normal memory path, and a memory-wait timeout that raises a bus error.
- Sits between the instruction decoder, the memory interface and the PC/stack logic.

Parameters:
- NUM_IRQ, 4: number of interrupt request lines (1..16).
- IRQ_ID_W, 2: width of O_irq_id; must equal max(1, clog2(NUM_IRQ)).
- IRQ_WAIT, 2: cycles spent in IRQ_ID before SAVE_PC (>=1).
- MEM_TIMEOUT, 15: max cycles in FETCH/MEM without completion before abort; 0 disables the timeout.

Ports:
- I_clk  in  1  clock, rising edge.
- I_reset_n  in  1  asynchronous active-low reset.
- I_needs_mem  in  1  decoder: current instruction accesses memory; sampled in DECODE.
- I_mem_write  in  1  decoder: access is a write (completion on I_mem_ready); sampled in DECODE.
- I_mem_ready  in  1  memory ready / write-complete.
- I_data_ready  in  1  read data valid.
- I_irq_enabled  in  1  global interrupt enable.
- I_irq_req  in  NUM_IRQ  level interrupt requests.
- I_irq_mask  in  NUM_IRQ  1 = line masked.
- O_state  out  9  one-hot state.
- O_execute  out  1  one-cycle memory-issue strobe.
- O_irq_ack  out  1  one-cycle acknowledge.
- O_irq_id  out  IRQ_ID_W  ID of the acknowledged line; held until the next ack.
- O_push_pc  out  1  high from SAVE_PC until ISR entry.
- O_bus_error  out  1  one-cycle strobe on timeout.

Behaviour:
- Reset (async, any state): O_state = FETCH (9'b000000001). O_execute, O_irq_ack, O_push_pc, O_bus_error and O_irq_id are all 0. Internal mem_wait, saving, the wait counter and the latched decode bits are cleared.
- States (one-hot):
  - FETCH = bit0, DECODE = bit1, REGREAD = bit2, EXECUTE = bit3, MEM = bit4.
  - WRITEBACK = bit5, IRQ_ID = bit6, SAVE_PC = bit7, ENTER_ISR = bit8.
- Memory handshake (FETCH, MEM):
  - First cycle with I_mem_ready = 1 and mem_wait = 0: O_execute = 1 for exactly one cycle, mem_wait <= 1.
  - While mem_wait = 1, completion is I_data_ready for reads/fetch and I_mem_ready for writes.
  - Completion is ignored in the issue cycle itself.
  - On completion: mem_wait <= 0 and advance. FETCH goes to DECODE; MEM goes to WRITEBACK.
- Timeout:
  - The counter resets on entry to FETCH/MEM and increments each cycle in state without completion.
  - When it reaches MEM_TIMEOUT (MEM_TIMEOUT > 0): O_bus_error = 1 for one cycle, mem_wait <= 0, next state WRITEBACK (from either FETCH or MEM).
  - Completion and timeout in the same cycle: completion wins, no error.
- DECODE: latch I_needs_mem and I_mem_write; go to REGREAD. REGREAD goes to EXECUTE (1 cycle).
- EXECUTE: go to MEM if the latched needs_mem = 1, else WRITEBACK. No issue happens in EXECUTE; MEM performs it.
- Non-memory instruction latency: FETCH completion to the next FETCH = 4 cycles (DECODE, REGREAD, EXECUTE, WRITEBACK).
- Interrupt priority:
  - pending = I_irq_req & ~I_irq_mask.
  - The lowest set index wins. Evaluated combinationally in WRITEBACK only.
- WRITEBACK, checked in order:
  1. saving = 1: saving <= 0, O_push_pc <= 0, go to ENTER_ISR. Interrupts are not re-checked.
  2. I_irq_enabled and pending != 0: O_irq_ack = 1 for one cycle, O_irq_id <= winning index, go to IRQ_ID.
  3. Otherwise go to FETCH.
- A request dropping after ack does not cancel the sequence.
- IRQ_ID: stay IRQ_WAIT cycles, then go to SAVE_PC.
- SAVE_PC: O_push_pc <= 1, saving <= 1, force latched needs_mem = 1 and mem_write = 1, go to MEM. The push is a write; a timeout here still ends in WRITEBACK with saving = 1.
- ENTER_ISR: 1 cycle, then FETCH.
- Simultaneous requests: only one ID is acked per WRITEBACK; the rest wait for the next instruction boundary.

Test Plan:
- Reset mid-MEM (I_reset_n low for 1 cycle during mem_wait): O_state = 1 immediately, all strobes 0, and the next fetch issues O_execute normally.
- ALU instruction (I_needs_mem = 0), memory responding in 1 cycle: O_state sequence 1, 2, 4, 8, 32, 1; exactly one O_execute pulse.
- Read: I_needs_mem = 1, I_mem_write = 0, I_data_ready 3 cycles after issue → MEM held 4 cycles, then WRITEBACK. A write with I_mem_ready held high completes the cycle after issue.
- Interrupt priority: I_irq_req = 4'b1010, I_irq_mask = 4'b0010, enabled → O_irq_ack pulse and O_irq_id = 3; then IRQ_ID for 2 cycles, SAVE_PC, MEM with O_push_pc = 1, WRITEBACK, ENTER_ISR (256), FETCH, with O_push_pc = 0.
- Interrupts blocked: I_irq_enabled = 0, or all pending lines masked → no ack, WRITEBACK goes to FETCH.
- Timeout: MEM_TIMEOUT = 15, I_data_ready never asserted in FETCH → O_bus_error pulses on the 15th wait cycle, then state 32 and back to 1. With I_data_ready on the same cycle, no error is raised and the state goes to 2.
